// File: rtl/player_mover.sv
// player_mover: tick-driven player token controller that probes wall_check before committing a step.
// Optional goal detection / movement freeze is compiled in when PLAYER_GOAL_EN is defined.
module player_mover #(
  parameter int unsigned MAP_W       = 20,
  parameter int unsigned MAP_H       = 10,
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 1,
  parameter int unsigned MOVE_PERIOD = 4,
  parameter int unsigned GOAL_X      = 18,
  parameter int unsigned GOAL_Y      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [4:0] query_x,
  output logic [4:0] query_y,
  input  logic       is_wall,
  output logic [4:0] player_x,
  output logic [4:0] player_y,
  output logic       move_done,
  output logic       bump,
  output logic       at_goal
);

  localparam int unsigned POS_W  = 5;
  localparam int unsigned CAND_W = 6;
  localparam int unsigned CD_W   = 4;

  localparam logic signed [CAND_W-1:0] MAP_W_S = CAND_W'(MAP_W);
  localparam logic signed [CAND_W-1:0] MAP_H_S = CAND_W'(MAP_H);

  // Parameter sanity, caught at elaboration
  if (MOVE_PERIOD < 1 || MOVE_PERIOD > 15) begin : g_bad_period
    $error("player_mover: MOVE_PERIOD must be in 1..15");
  end
  if (MAP_W > 31 || MAP_H > 31 || START_X >= MAP_W || START_Y >= MAP_H) begin : g_bad_map
    $error("player_mover: map size or start tile out of range");
  end
  if (GOAL_X >= MAP_W || GOAL_Y >= MAP_H) begin : g_bad_goal
    $error("player_mover: goal tile out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [POS_W-1:0] player_x_nxt, player_y_nxt;
  logic [POS_W-1:0] query_x_nxt, query_y_nxt;
  logic [POS_W-1:0] cand_x, cand_y, cand_x_nxt, cand_y_nxt;
  logic             force_wall, force_wall_nxt;
  logic [CD_W-1:0]  cooldown, cooldown_nxt;
  logic             move_done_nxt, bump_nxt;
  logic             any_btn, in_bounds, wall_c, frozen;

  logic signed [CAND_W-1:0] step_x, step_y, try_x, try_y;

`ifdef PLAYER_GOAL_EN
  logic at_goal_nxt;
  logic goal_hit;

  assign goal_hit = (cand_x == POS_W'(GOAL_X)) && (cand_y == POS_W'(GOAL_Y));
  assign frozen   = at_goal;
`else
  assign at_goal = 1'b0;
  assign frozen  = 1'b0;
`endif

  assign any_btn = btn_up | btn_down | btn_left | btn_right;
  assign wall_c  = is_wall | force_wall;

  // Single direction chosen by fixed priority: up > down > left > right
  always_comb begin
    step_x = '0;
    step_y = '0;
    if (btn_up) begin
      step_y = CAND_W'(1);
    end else if (btn_down) begin
      step_y = -CAND_W'(1);
    end else if (btn_left) begin
      step_x = -CAND_W'(1);
    end else if (btn_right) begin
      step_x = CAND_W'(1);
    end
  end

  assign try_x     = $signed({1'b0, player_x}) + step_x;
  assign try_y     = $signed({1'b0, player_y}) + step_y;
  assign in_bounds = (try_x >= 0) && (try_x < MAP_W_S) &&
                     (try_y >= 0) && (try_y < MAP_H_S);

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state;
    player_x_nxt   = player_x;
    player_y_nxt   = player_y;
    query_x_nxt    = query_x;
    query_y_nxt    = query_y;
    cand_x_nxt     = cand_x;
    cand_y_nxt     = cand_y;
    force_wall_nxt = force_wall;
    cooldown_nxt   = cooldown;
    move_done_nxt  = 1'b0;
    bump_nxt       = 1'b0;
`ifdef PLAYER_GOAL_EN
    at_goal_nxt    = at_goal;
`endif

    case (state)
      IDLE: begin
        query_x_nxt = player_x;
        query_y_nxt = player_y;
        if (tick && !frozen) begin
          if (!any_btn) begin
            cooldown_nxt = '0;
          end else if (cooldown != '0) begin
            cooldown_nxt = cooldown - CD_W'(1);
          end else begin
            cand_x_nxt     = try_x[POS_W-1:0];
            cand_y_nxt     = try_y[POS_W-1:0];
            force_wall_nxt = !in_bounds;
            // Off-map candidates never reach wall_check; the query stays on the player tile
            if (in_bounds) begin
              query_x_nxt = try_x[POS_W-1:0];
              query_y_nxt = try_y[POS_W-1:0];
            end
            state_nxt = CHECK;
          end
        end
      end

      CHECK: begin
        if (!wall_c) begin
          player_x_nxt  = cand_x;
          player_y_nxt  = cand_y;
          query_x_nxt   = cand_x;
          query_y_nxt   = cand_y;
          move_done_nxt = 1'b1;
`ifdef PLAYER_GOAL_EN
          if (goal_hit) begin
            at_goal_nxt = 1'b1;
          end
`endif
        end else begin
          query_x_nxt = player_x;
          query_y_nxt = player_y;
          bump_nxt    = 1'b1;
        end
        cooldown_nxt = CD_W'(MOVE_PERIOD - 1);
        state_nxt    = RESOLVE;
      end

      RESOLVE: begin
        query_x_nxt = player_x;
        query_y_nxt = player_y;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      player_x   <= POS_W'(START_X);
      player_y   <= POS_W'(START_Y);
      query_x    <= POS_W'(START_X);
      query_y    <= POS_W'(START_Y);
      cand_x     <= POS_W'(START_X);
      cand_y     <= POS_W'(START_Y);
      force_wall <= 1'b0;
      cooldown   <= '0;
      move_done  <= 1'b0;
      bump       <= 1'b0;
`ifdef PLAYER_GOAL_EN
      at_goal    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      player_x   <= player_x_nxt;
      player_y   <= player_y_nxt;
      query_x    <= query_x_nxt;
      query_y    <= query_y_nxt;
      cand_x     <= cand_x_nxt;
      cand_y     <= cand_y_nxt;
      force_wall <= force_wall_nxt;
      cooldown   <= cooldown_nxt;
      move_done  <= move_done_nxt;
      bump       <= bump_nxt;
`ifdef PLAYER_GOAL_EN
      at_goal    <= at_goal_nxt;
`endif
    end
  end

endmodule
